// File: rtl/alu_share_if.sv
// Request/response bundle between two ALU clients and the shared ALU arbiter.
interface alu_share_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_ovf;
  logic             rsp_err;
  logic [CNT_W-1:0] ops_done;
  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp_data, rsp_carry, rsp_zero,
    input  rsp_ovf, rsp_err, ops_done, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp_data, rsp_carry, rsp_zero,
    output rsp_ovf, rsp_err, ops_done, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU_32 between two clients,
// with registered operands, qualified flags and a completion counter.
module ALU_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [3:0]       ALU_ctrl,
  output logic [WIDTH-1:0] ALU_out,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic           add_ovf;
  logic           sub_ovf;
  logic           slt;

  always_comb begin
    sum = {1'b0, A_in} + {1'b0, B_in};
    dif = {1'b0, A_in} - {1'b0, B_in};
    add_ovf = (A_in[WIDTH-1] == B_in[WIDTH-1]) &&
              (sum[WIDTH-1] != A_in[WIDTH-1]);
    sub_ovf = (A_in[WIDTH-1] != B_in[WIDTH-1]) &&
              (dif[WIDTH-1] != A_in[WIDTH-1]);
    slt = $signed(A_in) < $signed(B_in);
    ALU_out = '0;
    carry_out = 1'b0;
    overflow = 1'b0;
    case (ALU_ctrl)
      4'b0000: ALU_out = A_in & B_in;
      4'b0001: ALU_out = A_in | B_in;
      4'b0010: begin
        ALU_out = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
        overflow = add_ovf;
      end
      4'b0110: begin
        ALU_out = dif[WIDTH-1:0];
        carry_out = ~dif[WIDTH];
        overflow = sub_ovf;
      end
      4'b0111: ALU_out = {{(WIDTH-1){1'b0}}, slt};
      4'b1100: ALU_out = ~(A_in | B_in);
      4'b1111: ALU_out = {{(WIDTH-1){1'b0}}, A_in == B_in};
      default: ALU_out = '0;
    endcase
    zero = (ALU_out == '0);
  end
endmodule

module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  alu_share_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [1:0]       vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_ovf;
  logic             grant0;
  logic             grant1;
  logic             legal;
  logic             rsp_rdy;

  ALU_32 #(.WIDTH(WIDTH)) u_alu (
    .A_in     (a_q),
    .B_in     (b_q),
    .ALU_ctrl (op_q),
    .ALU_out  (alu_out),
    .carry_out(alu_carry),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  // last_q names the previous winner; the other side wins a tie
  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);

  assign bus.req0_ready = !rst && state_q == IDLE && grant0;
  assign bus.req1_ready = !rst && state_q == IDLE && grant1;

  assign legal = op_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0110,
                              4'b0111, 4'b1100, 4'b1111};
  assign rsp_rdy = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant0: begin
            op_d    = bus.req0_op;
            a_d     = bus.req0_a;
            b_d     = bus.req0_b;
            gnt_d   = 1'b0;
            last_d  = 1'b0;
            state_d = EXEC;
          end
          grant1: begin
            op_d    = bus.req1_op;
            a_d     = bus.req1_a;
            b_d     = bus.req1_b;
            gnt_d   = 1'b1;
            last_d  = 1'b1;
            state_d = EXEC;
          end
          default: ;
        endcase
      end
      EXEC: begin
        data_d  = legal ? alu_out : '0;
        zero_d  = legal ? alu_zero : 1'b1;
        carry_d = legal && op_q == OP_ADD && alu_carry;
        ovf_d   = legal && (op_q == OP_ADD || op_q == OP_SUB) && alu_ovf;
        err_d   = !legal;
        vld_d   = gnt_q ? 2'b10 : 2'b01;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_rdy) begin
          vld_d   = 2'b00;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rsp0_valid = vld_q[0];
  assign bus.rsp1_valid = vld_q[1];
  assign bus.rsp_data   = data_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.rsp_err    = err_q;
  assign bus.ops_done   = cnt_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU_32 instance between two requesters. Each requester issues one operation at a time over a valid/ready handshake.
- The block sits between the ALU_32 instance and two client units. It arbitrates round-robin, registers the operands, runs the ALU, then returns the registered result and flags on the winning requester's response channel.
- It also qualifies the flags per opcode, rejects illegal opcodes, and counts completed operations.

Parameters:
- WIDTH, 32, operand/result width; must match ALU_32.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an op pending
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  4  ALU_ctrl code from requester 0
- req0_a  in  WIDTH  operand A from requester 0
- req0_b  in  WIDTH  operand B from requester 0
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meanings, requester 1
- rsp0_valid  out  1  response for requester 0 available
- rsp0_ready  in  1  requester 0 consumes the response
- rsp1_valid  out  1  response for requester 1 available
- rsp1_ready  in  1  requester 1 consumes the response
- rsp_data  out  WIDTH  registered ALU_out (shared by both response channels)
- rsp_carry  out  1  qualified carry_out
- rsp_zero  out  1  registered zero flag
- rsp_ovf  out  1  qualified overflow
- rsp_err  out  1  opcode was illegal
- ops_done  out  CNT_W  count of completed responses
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - clk and rst only; reset is synchronous and active-high.
  - State = IDLE.
  - All ready/valid outputs = 0; rsp_data/flags/err = 0; ops_done = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1111 EQ. Every other code is illegal.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If no reqN_valid: stay in IDLE.
  - If exactly one valid: grant it.
  - If both valid: grant the requester != last_grant.
  - On grant:
    - Assert reqG_ready combinationally in that cycle. This is the only ready pulse, one cycle long.
    - Latch op/a/b into operand registers.
    - Set gnt = G and last_grant = G.
    - Go to EXEC.
- EXEC:
  - The ALU runs from the registered operands.
  - At the clock edge, capture ALU_out to rsp_data and zero to rsp_zero.
  - rsp_carry = carry_out when op == ADD, else 0.
  - rsp_ovf = overflow when op is ADD or SUB, else 0.
  - Illegal op: rsp_err = 1, rsp_data = 0, rsp_zero = 1, rsp_carry = 0, rsp_ovf = 0.
  - Go to RESP.
- RESP:
  - rspG_valid = 1; the other rsp valid = 0.
  - rsp_data/flags/err hold stable while valid.
  - When rspG_ready = 1: increment ops_done (wraps at 2^CNT_W - 1 -> 0), deassert rspG_valid on the next cycle, go to IDLE.
- Latency: acceptance at edge T gives rspG_valid high in cycle T+2, so back-to-back throughput is one op per 3 cycles minimum.
- No new request is accepted until RESP completes; reqN_ready = 0 in EXEC/RESP.
- rspN_ready while rspN_valid = 0 is ignored.
- A requester dropping reqN_valid before ready is allowed; nothing is latched.
- A requester whose valid rises in the same cycle it loses arbitration is served in the next IDLE visit.
- Reset mid-operation: the next edge returns to IDLE and discards the pending op. rsp valid falls and ops_done clears; no partial response is issued.
- The ALU_32 instance is internal; its ports are A_in, B_in, ALU_ctrl, ALU_out, carry_out, zero, overflow.

Test Plan:
- Req0 ADD, A=C182F088, B=D07915C2 -> req0_ready pulses 1 cycle; rsp0_valid 2 cycles later; rsp_data=91FC064A, carry=1, ovf=0, err=0; ops_done=1.
- Req1 SUB, A=B182F088, B=707915C3 -> rsp1_valid; rsp_data=4109DAC5, ovf=1, carry=0, zero=0; rsp0_valid stays 0.
- Both valid every cycle after reset: req0 NOR E491C062/5B7E7F9D, req1 SLT FFFFFFF9/00000006 ->
  - Grants alternate 0,1,0,1.
  - Req0 response is 00000000 with zero=1.
  - Req1 response is 00000001 with zero=0.
- Illegal op 0101 on req0 -> rsp_err=1, rsp_data=0, zero=1; next legal op (EQ 1/1 -> 00000001) has err=0.
- Hold rsp0_ready=0 for 5 cycles with req1_valid=1 ->
  - rsp0_valid and rsp_data stay stable.
  - req1_ready stays 0.
  - Req1 is granted in the first IDLE cycle after the handshake.
- Assert rst during EXEC ->
  - Next cycle: busy=0, no rsp valid, ops_done=0.
  - A subsequent contention grants requester 0 first.
